control: RTL and testbench
==========================

CONTROL -- requirements
Module: control

Interface
REQ-001 The ports SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction opcode, bits 31:26.
- MOC  in  1  memory operation complete, active-high.
- reg_dst  out  1  1=rd, 0=rt as destination.
- mem_to_reg  out  1  1=memory data written back, 0=ALU result.
- alu_fnc  out  5  ALU operation code.
- MOV  out  1  immediate move (LUI path).
- HILO  out  1  HI/LO register write.
- RAMEnable  out  1  memory access request.
- jump  out  1  PC load from jump target.
- branch  out  1  conditional PC load.
- RW  out  1  1=read, 0=write.
- alu_src  out  1  1=immediate, 0=rt.
- reg_write  out  1  register file write.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-003 States SHALL be FETCH, DECODE, EXEC, MEM and WB. Outputs SHALL be Moore-style, decoded from the state and the latched opcode.
REQ-004 FETCH SHALL drive RAMEnable=1 and RW=1. It SHALL stay in FETCH while MOC=0 and go to DECODE on a clock edge with MOC=1.
REQ-005 DECODE SHALL latch opcode into an internal register. All outputs SHALL be 0 and RW=1. The next state SHALL be EXEC.
REQ-006 EXEC SHALL drive alu_fnc, alu_src, reg_dst and MOV for the latched opcode; jump is asserted for J, branch for BEQ/BNE/BGTZ. Next state: loads/stores go to MEM; J, branches and unsupported opcodes go to FETCH; all others go to WB.
REQ-007 MEM SHALL hold the EXEC ALU signals and drive RAMEnable=1. RW SHALL be 1 for loads and 0 for stores. It SHALL stay in MEM while MOC=0. On MOC=1, loads go to WB and stores go to FETCH.
REQ-008 WB SHALL drive reg_write=1, mem_to_reg=1 only for loads, and hold reg_dst. For opcode 011100 it SHALL drive HILO=1 and reg_write=0. The next state SHALL be FETCH.
REQ-009 The opcode table (alu_fnc codes) SHALL be:
- 000000 R-type: reg_dst=1, alu_src=0, FUNCT=11111.
- 001001 ADDIU: ADD=00001.
- 001100 ANDI: AND=00011.
- 001101 ORI: OR=00100.
- 001110 XORI: XOR=00101.
- 001010 SLTI: SLT=00110.
- 001011 SLTIU: SLTU=00111.
- 001111 LUI: LUI=01000, MOV=1.
- 100000 LB, 100011 LW, 100100 LBU: ADD, alu_src=1, load.
- 101000 SB, 101011 SW: ADD, alu_src=1, store.
- 000100 BEQ, 000101 BNE, 000111 BGTZ: SUB=00010, alu_src=0.
- 000010 J: jump=1.
- 011100 MULT-class: FUNCT, HILO=1 in WB.
- Immediate ALU ops use alu_src=1, reg_dst=0.
REQ-010 Any opcode outside REQ-009 SHALL be a NOP: no write, no memory access, return to FETCH after EXEC.
REQ-011 Any output not specified for a state SHALL be 0, except RW, which defaults to 1.
REQ-012 A change of the opcode input outside DECODE SHALL have no effect on the outputs.
REQ-013 MOC SHALL be ignored in DECODE, EXEC and WB.

Reset
REQ-014 While reset=0, state SHALL be FETCH, the latched opcode 000000, all outputs 0 and RW=1. RAMEnable SHALL be forced to 0 while in reset.
REQ-015 Reset asserted mid-instruction SHALL abort it immediately, including inside a MEM wait.
REQ-016 The first rising edge after reset release SHALL begin a fetch with RAMEnable=1.

Structure
REQ-017 A package control_pkg SHALL hold the state enum, the opcode constants and the alu_fnc codes.
REQ-018 One combinational sub-module, control_decode, SHALL map the latched opcode to the static signal set. The FSM SHALL stay in control.

Verification
REQ-019 Reset held low, opcode=001001 -> all outputs 0, RW=1; after release, RAMEnable=1 and RW=1.
REQ-020 FETCH with MOC=0 for 3 cycles, then 1 -> state held for 3 cycles; DECODE follows.
REQ-021 opcode=001001 -> EXEC shows alu_fnc=00001, alu_src=1, reg_dst=0; WB shows reg_write=1, mem_to_reg=0.
REQ-022 opcode=100100 -> MEM shows RAMEnable=1, RW=1, waits for MOC; WB shows reg_write=1, mem_to_reg=1.
REQ-023 opcode=000111 -> EXEC shows branch=1, alu_fnc=00010; no WB, returns to FETCH. opcode=000000 -> reg_dst=1, alu_fnc=11111, reg_write=1 in WB.
REQ-024 opcode=101011 with reset pulled low during MEM -> outputs 0 immediately; the store never completes.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: states, opcodes, ALU codes and the decode/output bundles shared by the controller.
package control_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_MULT  = 6'b011100;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [4:0] ALU_ADD   = 5'b00001;
  localparam logic [4:0] ALU_SUB   = 5'b00010;
  localparam logic [4:0] ALU_AND   = 5'b00011;
  localparam logic [4:0] ALU_OR    = 5'b00100;
  localparam logic [4:0] ALU_XOR   = 5'b00101;
  localparam logic [4:0] ALU_SLT   = 5'b00110;
  localparam logic [4:0] ALU_SLTU  = 5'b00111;
  localparam logic [4:0] ALU_LUI   = 5'b01000;
  localparam logic [4:0] ALU_FUNCT = 5'b11111;
  typedef struct packed {
    logic [4:0] alu_fnc;
    logic       alu_src;
    logic       reg_dst;
    logic       mov;
    logic       jump;
    logic       branch;
    logic       load;
    logic       store;
    logic       hilo;
    logic       wb;
  } dec_t;
  typedef struct packed {
    logic       reg_dst;
    logic       mem_to_reg;
    logic [4:0] alu_fnc;
    logic       mov;
    logic       hilo;
    logic       ram_enable;
    logic       jump;
    logic       branch;
    logic       rw;
    logic       alu_src;
    logic       reg_write;
  } out_t;
  localparam out_t OUT_IDLE = '{rw: 1'b1, default: '0};
endpackage

// File: rtl/control_if.sv
// control_if: opcode/MOC inputs and the control word driven by the controller.
interface control_if;
  logic [5:0] opcode;
  logic       MOC;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [4:0] alu_fnc;
  logic       MOV;
  logic       HILO;
  logic       RAMEnable;
  logic       jump;
  logic       branch;
  logic       RW;
  logic       alu_src;
  logic       reg_write;
  modport master (
    output opcode, MOC,
    input  reg_dst, mem_to_reg, alu_fnc, MOV, HILO, RAMEnable, jump, branch, RW, alu_src, reg_write
  );
  modport slave (
    input  opcode, MOC,
    output reg_dst, mem_to_reg, alu_fnc, MOV, HILO, RAMEnable, jump, branch, RW, alu_src, reg_write
  );
endinterface

// File: rtl/control_decode.sv
// control_decode: maps an opcode to its static control signal set; unknown opcodes decode to all-zero (NOP).
module control_decode
  import control_pkg::*;
(
  input  logic [5:0] opcode,
  output dec_t       dec
);
  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.alu_fnc = ALU_FUNCT;
        dec.reg_dst = 1'b1;
        dec.wb      = 1'b1;
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: begin
        dec.alu_fnc = opcode == OP_ADDIU ? ALU_ADD :
                      opcode == OP_ANDI  ? ALU_AND :
                      opcode == OP_ORI   ? ALU_OR  :
                      opcode == OP_XORI  ? ALU_XOR :
                      opcode == OP_SLTI  ? ALU_SLT :
                      opcode == OP_SLTIU ? ALU_SLTU : ALU_LUI;
        dec.alu_src = 1'b1;
        dec.mov     = opcode == OP_LUI;
        dec.wb      = 1'b1;
      end
      OP_LB, OP_LW, OP_LBU: begin
        dec.alu_fnc = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.load    = 1'b1;
        dec.wb      = 1'b1;
      end
      OP_SB, OP_SW: begin
        dec.alu_fnc = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.store   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BGTZ: begin
        dec.alu_fnc = ALU_SUB;
        dec.branch  = 1'b1;
      end
      OP_J: dec.jump = 1'b1;
      OP_MULT: begin
        dec.alu_fnc = ALU_FUNCT;
        dec.hilo    = 1'b1;
        dec.wb      = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/control.sv
// control: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with registered Moore outputs.
// Outputs are computed for the next state so the flops always show the current state's control word.
module control
  import control_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  control_if.slave  bus
);
  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  out_t       out_q, out_d;
  dec_t       dec;
  control_decode u_decode (.opcode(op_d), .dec(dec));
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      FETCH:   state_d = bus.MOC && out_q.ram_enable ? DECODE : FETCH;
      DECODE: begin
        op_d    = bus.opcode;
        state_d = EXEC;
      end
      EXEC:    state_d = dec.load || dec.store ? MEM : dec.wb ? WB : FETCH;
      MEM:     state_d = !bus.MOC ? MEM : dec.load ? WB : FETCH;
      default: state_d = FETCH;
    endcase
    out_d = OUT_IDLE;
    case (state_d)
      FETCH: out_d.ram_enable = 1'b1;
      EXEC, MEM: begin
        out_d.alu_fnc    = dec.alu_fnc;
        out_d.alu_src    = dec.alu_src;
        out_d.reg_dst    = dec.reg_dst;
        out_d.mov        = dec.mov;
        out_d.jump       = dec.jump && state_d == EXEC;
        out_d.branch     = dec.branch && state_d == EXEC;
        out_d.ram_enable = state_d == MEM;
        out_d.rw         = state_d == EXEC || dec.load;
      end
      WB: begin
        out_d.reg_write  = !dec.hilo;
        out_d.hilo       = dec.hilo;
        out_d.mem_to_reg = dec.load;
        out_d.reg_dst    = dec.reg_dst;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      out_q   <= OUT_IDLE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end
  assign bus.reg_dst    = out_q.reg_dst;
  assign bus.mem_to_reg = out_q.mem_to_reg;
  assign bus.alu_fnc    = out_q.alu_fnc;
  assign bus.MOV        = out_q.mov;
  assign bus.HILO       = out_q.hilo;
  assign bus.RAMEnable  = out_q.ram_enable;
  assign bus.jump       = out_q.jump;
  assign bus.branch     = out_q.branch;
  assign bus.RW         = out_q.rw;
  assign bus.alu_src    = out_q.alu_src;
  assign bus.reg_write  = out_q.reg_write;
endmodule

// File: tb/tb_control.sv
// tb_control: drives instruction sequences with random waits/noise and checks every cycle against a per-phase model.
module tb_control;
  typedef struct packed {
    logic       reg_dst;
    logic       mem_to_reg;
    logic [4:0] alu_fnc;
    logic       mov;
    logic       hilo;
    logic       ram;
    logic       jump;
    logic       branch;
    logic       rw;
    logic       alu_src;
    logic       reg_write;
  } ov_t;
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4;
  localparam ov_t IDLE = 15'h0004;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  ov_t  cap_q[$];
  int   ph_q[$];
  control_if bus ();
  control dut (.clk(clk), .reset(reset), .bus(bus));
  initial forever #5 clk = ~clk;
  function automatic ov_t sample();
    ov_t o;
    o.reg_dst = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.alu_fnc = bus.alu_fnc;
    o.mov = bus.MOV;
    o.hilo = bus.HILO;
    o.ram = bus.RAMEnable;
    o.jump = bus.jump;
    o.branch = bus.branch;
    o.rw = bus.RW;
    o.alu_src = bus.alu_src;
    o.reg_write = bus.reg_write;
    return o;
  endfunction
  function automatic bit is_load(logic [5:0] op);
    return op inside {6'b100000, 6'b100011, 6'b100100};
  endfunction
  function automatic bit is_store(logic [5:0] op);
    return op inside {6'b101000, 6'b101011};
  endfunction
  function automatic bit is_imm(logic [5:0] op);
    return op inside {6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011, 6'b001111};
  endfunction
  function automatic bit is_branch(logic [5:0] op);
    return op inside {6'b000100, 6'b000101, 6'b000111};
  endfunction
  function automatic bit has_wb(logic [5:0] op);
    return op == 6'b000000 || op == 6'b011100 || is_imm(op) || is_load(op);
  endfunction
  function automatic logic [4:0] fnc_of(logic [5:0] op);
    case (op)
      6'b000000, 6'b011100: return 5'b11111;
      6'b001001, 6'b100000, 6'b100011, 6'b100100, 6'b101000, 6'b101011: return 5'b00001;
      6'b001100: return 5'b00011;
      6'b001101: return 5'b00100;
      6'b001110: return 5'b00101;
      6'b001010: return 5'b00110;
      6'b001011: return 5'b00111;
      6'b001111: return 5'b01000;
      6'b000100, 6'b000101, 6'b000111: return 5'b00010;
      default: return 5'b00000;
    endcase
  endfunction
  function automatic ov_t exp_of(int ph, logic [5:0] op);
    ov_t o = IDLE;
    if (ph == P_FETCH) o.ram = 1'b1;
    if (ph == P_EXEC || ph == P_MEM) begin
      o.alu_fnc = fnc_of(op);
      o.alu_src = is_imm(op) || is_load(op) || is_store(op);
      o.reg_dst = op == 6'b000000;
      o.mov = op == 6'b001111;
    end
    if (ph == P_EXEC) begin
      o.jump = op == 6'b000010;
      o.branch = is_branch(op);
    end
    if (ph == P_MEM) begin
      o.ram = 1'b1;
      o.rw = is_load(op);
    end
    if (ph == P_WB) begin
      o.reg_write = op != 6'b011100;
      o.hilo = op == 6'b011100;
      o.mem_to_reg = is_load(op);
      o.reg_dst = op == 6'b000000;
    end
    return o;
  endfunction
  // Runs one instruction from FETCH back to FETCH, capturing outputs each cycle; opcode is only valid in DECODE.
  task automatic exec_instr(logic [5:0] op, int fw, int mw);
    cap_q.delete();
    ph_q.delete();
    for (int i = 0; i <= fw; i++) begin
      cap_q.push_back(sample()); ph_q.push_back(P_FETCH);
      bus.MOC = (i == fw); bus.opcode = 6'($urandom);
      @(negedge clk);
    end
    cap_q.push_back(sample()); ph_q.push_back(P_DECODE);
    bus.MOC = 1'($urandom); bus.opcode = op;
    @(negedge clk);
    cap_q.push_back(sample()); ph_q.push_back(P_EXEC);
    bus.MOC = 1'($urandom); bus.opcode = 6'($urandom);
    @(negedge clk);
    if (is_load(op) || is_store(op))
      for (int i = 0; i <= mw; i++) begin
        cap_q.push_back(sample()); ph_q.push_back(P_MEM);
        bus.MOC = (i == mw); bus.opcode = 6'($urandom);
        @(negedge clk);
      end
    if (has_wb(op)) begin
      cap_q.push_back(sample()); ph_q.push_back(P_WB);
      bus.MOC = 1'($urandom); bus.opcode = 6'($urandom);
      @(negedge clk);
    end
    bus.MOC = 1'b0;
  endtask
  task automatic test_reset();
    bus.opcode = 6'b001001; bus.MOC = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (sample() !== IDLE) begin miscompares++; $display("FAIL reset_hold: got %h want %h", sample(), IDLE); end
    bus.MOC = 1'b1;
    @(negedge clk);
    vectors++;
    if (sample() !== IDLE) begin miscompares++; $display("FAIL reset_moc: got %h want %h", sample(), IDLE); end
    bus.MOC = 1'b0; reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (sample() !== exp_of(P_FETCH, 6'b0)) begin miscompares++; $display("FAIL reset_release: got %h want %h", sample(), exp_of(P_FETCH, 6'b0)); end
  endtask
  task automatic test_fetch_wait();
    exec_instr(6'b001001, 3, 0);
    foreach (cap_q[i]) begin
      vectors++;
      if (cap_q[i] !== exp_of(ph_q[i], 6'b001001)) begin miscompares++; $display("FAIL fetch_wait c%0d ph%0d: got %h want %h", i, ph_q[i], cap_q[i], exp_of(ph_q[i], 6'b001001)); end
    end
  endtask
  task automatic test_load();
    exec_instr(6'b100100, 1, 3);
    foreach (cap_q[i]) begin
      vectors++;
      if (cap_q[i] !== exp_of(ph_q[i], 6'b100100)) begin miscompares++; $display("FAIL load c%0d ph%0d: got %h want %h", i, ph_q[i], cap_q[i], exp_of(ph_q[i], 6'b100100)); end
    end
  endtask
  task automatic test_branch_rtype();
    logic [5:0] ops [4] = '{6'b000111, 6'b000000, 6'b000010, 6'b011100};
    foreach (ops[k]) begin
      exec_instr(ops[k], 0, 0);
      foreach (cap_q[i]) begin
        vectors++;
        if (cap_q[i] !== exp_of(ph_q[i], ops[k])) begin miscompares++; $display("FAIL ctl op%b c%0d ph%0d: got %h want %h", ops[k], i, ph_q[i], cap_q[i], exp_of(ph_q[i], ops[k])); end
      end
    end
  endtask
  task automatic test_random();
    logic [5:0] ops [18] = '{6'b000000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010,
                             6'b001011, 6'b001111, 6'b100000, 6'b100011, 6'b100100, 6'b101000,
                             6'b101011, 6'b000100, 6'b000101, 6'b000111, 6'b000010, 6'b011100};
    for (int n = 0; n < 40; n++) begin
      int idx = int'($urandom_range(0, 19));
      logic [5:0] op = idx >= 18 ? 6'($urandom) : ops[idx];
      exec_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      foreach (cap_q[i]) begin
        vectors++;
        if (cap_q[i] !== exp_of(ph_q[i], op)) begin miscompares++; $display("FAIL random op%b c%0d ph%0d: got %h want %h", op, i, ph_q[i], cap_q[i], exp_of(ph_q[i], op)); end
      end
    end
  endtask
  task automatic test_reset_in_mem();
    bus.MOC = 1'b1;
    @(negedge clk);
    bus.MOC = 1'b0; bus.opcode = 6'b101011;
    @(negedge clk);
    bus.opcode = 6'b001001;
    @(negedge clk);
    vectors++;
    if (sample() !== exp_of(P_MEM, 6'b101011)) begin miscompares++; $display("FAIL sw_mem: got %h want %h", sample(), exp_of(P_MEM, 6'b101011)); end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (sample() !== IDLE) begin miscompares++; $display("FAIL sw_abort: got %h want %h", sample(), IDLE); end
    bus.MOC = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (sample() !== IDLE) begin miscompares++; $display("FAIL sw_abort_hold: got %h want %h", sample(), IDLE); end
    bus.MOC = 1'b0; reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (sample() !== exp_of(P_FETCH, 6'b0)) begin miscompares++; $display("FAIL sw_refetch: got %h want %h", sample(), exp_of(P_FETCH, 6'b0)); end
    exec_instr(6'b100011, 0, 1);
    foreach (cap_q[i]) begin
      vectors++;
      if (cap_q[i] !== exp_of(ph_q[i], 6'b100011)) begin miscompares++; $display("FAIL recover c%0d ph%0d: got %h want %h", i, ph_q[i], cap_q[i], exp_of(ph_q[i], 6'b100011)); end
    end
  endtask
  initial begin
    test_reset();
    test_fetch_wait();
    test_load();
    test_branch_rtype();
    test_random();
    test_reset_in_mem();
    vectors++;
    if (sample() !== exp_of(P_FETCH, 6'b0)) begin miscompares++; $display("FAIL final_fetch: got %h want %h", sample(), exp_of(P_FETCH, 6'b0)); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
